// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - RV funct3 load/store size codes
//   - arbiter state encoding
//   - default data-memory depth (log2 of 32-bit words)
//   - small helpers for request validity checks
package dmem_arb_pkg;

    localparam int unsigned DMEM_POWER_DEF = 18;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Codes 011, 110 and 111 have no load/store meaning.
    function automatic logic size_valid(input logic [2:0] size);
        size_valid = (size == F3_B) || (size == F3_H) || (size == F3_W) ||
                     (size == F3_BU) || (size == F3_HU);
    endfunction

    // Halves need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
        case (size[1:0])
            2'b01:   misaligned = lo[0];
            2'b10:   misaligned = (lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational byte/half lane logic for the data-memory arbiter.
// Ports:
//   size       in   3   RV funct3 size code
//   byte_off   in   2   address bits [1:0]
//   word       in  32   memory word (read data or merge buffer)
//   wdata      in  32   right-aligned store data
//   load_data  out 32   selected byte/half/word, sign- or zero-extended
//   merge_data out 32   word with the addressed byte/half replaced by wdata
module dmem_lane
    import dmem_arb_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  bit_off;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    always_comb begin
        bit_off = {byte_off, 3'b000};
        shifted = word >> bit_off;

        case (size)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h000000, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0000, shifted[15:0]};
            default: load_data = word;
        endcase

        case (size[1:0])
            2'b00:   lane_mask = 32'h0000_00FF << bit_off;
            2'b01:   lane_mask = 32'h0000_FFFF << bit_off;
            default: lane_mask = '1;
        endcase

        merge_data = (word & ~lane_mask) | ((wdata << bit_off) & lane_mask);
    end

endmodule

// File: rtl/dmem_arb.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Port 0 is the CPU load/store unit, port 1 is debug/DMA. Sub-word stores
// are done as read-modify-write through a merge buffer.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   pN_req/we/size/addr/wdata      request from port N (held until ack)
//   pN_ack/err/rdata               one-cycle completion, error, load data
//   mem_we/mem_a/mem_wd            memory write strobe, word address, write word
//   mem_rd                         combinational memory read word at mem_a
module dmem_arb #(
    parameter int unsigned DMEM_POWER = dmem_arb_pkg::DMEM_POWER_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_size,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_size,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    import dmem_arb_pkg::*;

    localparam logic [32:0] ADDR_LIMIT = 33'd4 << DMEM_POWER;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [31:0] merge_q, merge_d;
    logic        p0_err_q, p0_err_d;
    logic        p1_err_q, p1_err_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;

    logic        any_req;
    logic        gnt_idle;
    logic        sel;
    logic        s_we;
    logic [2:0]  s_size;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        req_err;
    logic        res_err;
    logic [31:0] res_rdata;
    logic [31:0] lane_word;
    logic [31:0] lane_load;
    logic [31:0] lane_merge;

    // Grant selection: a contest goes to the port not granted last time.
    always_comb begin
        any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            gnt_idle = ~last_q;
        end else begin
            gnt_idle = p1_req;
        end
        // In IDLE the fresh grant steers the datapath; afterwards the latched one.
        sel     = (state_q == ST_IDLE) ? gnt_idle : gnt_q;
        s_we    = sel ? p1_we    : p0_we;
        s_size  = sel ? p1_size  : p0_size;
        s_addr  = sel ? p1_addr  : p0_addr;
        s_wdata = sel ? p1_wdata : p0_wdata;
        req_err = !size_valid(s_size) || misaligned(s_size, s_addr[1:0]) ||
                  ({1'b0, s_addr} >= ADDR_LIMIT);
        lane_word = (state_q == ST_MERGE) ? merge_q : mem_rd;
    end

    dmem_lane u_lane (
        .size       (s_size),
        .byte_off   (s_addr[1:0]),
        .word       (lane_word),
        .wdata      (s_wdata),
        .load_data  (lane_load),
        .merge_data (lane_merge)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        merge_d    = merge_q;
        p0_err_d   = p0_err_q;
        p1_err_d   = p1_err_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        res_err    = 1'b0;
        res_rdata  = '0;
        mem_we     = 1'b0;
        mem_a      = {s_addr[31:2], 2'b00};
        mem_wd     = s_wdata;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = gnt_idle;
                    last_d  = gnt_idle;
                    state_d = ST_RESP;
                    res_err = req_err;
                    if (!req_err) begin
                        if (!s_we) begin
                            res_rdata = lane_load;
                        end else if (s_size[1:0] == 2'b10) begin
                            mem_we = 1'b1;
                        end else begin
                            merge_d = mem_rd;
                            state_d = ST_MERGE;
                        end
                    end
                    if (gnt_idle) begin
                        p1_err_d   = res_err;
                        p1_rdata_d = res_rdata;
                    end else begin
                        p0_err_d   = res_err;
                        p0_rdata_d = res_rdata;
                    end
                end
            end
            ST_MERGE: begin
                mem_we  = 1'b1;
                mem_wd  = lane_merge;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            merge_q    <= '0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            merge_q    <= merge_d;
            p0_err_q   <= p0_err_d;
            p1_err_q   <= p1_err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign p0_ack   = (state_q == ST_RESP) && !gnt_q;
    assign p1_ack   = (state_q == ST_RESP) &&  gnt_q;
    assign p0_err   = p0_err_q;
    assign p1_err   = p1_err_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arb.sv
module tb_dmem_arb;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  lat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic        p0_we = 1'b0, p1_we = 1'b0;
    logic [2:0]  p0_size = 3'b010, p1_size = 3'b010;
    logic [31:0] p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;

    int n_assert = 0;
    int n_fail   = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  we_cnt;
    int  we_k;
    logic [31:0] we_wd;

    dmem_arb #(.DMEM_POWER(18)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on posedge.
    assign mem_rd = mem[mem_a[11:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[11:2]] <= mem_wd;
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic ev_t mk_ev(input logic port, input logic err,
                                  input logic [31:0] rdata, input int lat);
        ev_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rdata;
        e.lat   = 8'(lat);
        return e;
    endfunction

    task automatic drive(input logic port, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
    endtask

    // Called at a negedge right after driving; step k=0 is the cycle the
    // request is first visible. Records acks and write strobes, drops req on ack.
    task automatic wait_acks(input int n);
        int got = 0;
        we_cnt = 0;
        we_k   = -1;
        we_wd  = '0;
        for (int k = 0; k < 40 && got < n; k++) begin
            #1;
            if (mem_we) begin
                we_cnt++;
                we_k  = k;
                we_wd = mem_wd;
            end
            if (p0_ack) begin
                obs_q.push_back(mk_ev(1'b0, p0_err, p0_rdata, k));
                p0_req = 1'b0;
                got++;
            end
            if (p1_ack) begin
                obs_q.push_back(mk_ev(1'b1, p1_err, p1_rdata, k));
                p1_req = 1'b0;
                got++;
            end
            @(negedge clk);
        end
        if (got < n) begin
            n_assert++;
            n_fail++;
            $display("FAIL ack_timeout: got %0d acks, want %0d", got, n);
            p0_req = 1'b0;
            p1_req = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_assert++;
        if ({p0_ack, p1_ack, p0_err, p1_err, mem_we} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {p0_ack, p1_ack, p0_err, p1_err, mem_we});
        end
        n_assert++;
        if ({p0_rdata, p1_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h want 0 0", p0_rdata, p1_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_rw;
        ev_t e, o;
        exp_q.push_back(mk_ev(1'b0, 1'b0, 32'h0, 1));
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        wait_acks(1);
        n_assert++;
        if (we_cnt !== 1 || we_k !== 0 || we_wd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL sw_strobe: cnt %0d k %0d wd %h want 1 0 deadbeef", we_cnt, we_k, we_wd);
        end
        exp_q.push_back(mk_ev(1'b0, 1'b0, 32'hDEADBEEF, 1));
        drive(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        wait_acks(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_rw_missing: got none want port %0d rdata %h", e.port, e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL word_rw: got p%0d err %0d rdata %h lat %0d want p%0d err %0d rdata %h lat %0d",
                             o.port, o.err, o.rdata, o.lat, e.port, e.err, e.rdata, e.lat);
                end
            end
        end
    endtask

    task automatic test_subword_store;
        ev_t e, o;
        exp_q.push_back(mk_ev(1'b1, 1'b0, 32'h0, 2));
        drive(1'b1, 1'b1, 3'b000, 32'h11, 32'h0000_0055);
        wait_acks(1);
        n_assert++;
        if (we_cnt !== 1 || we_k !== 1 || we_wd !== 32'hDEAD55EF) begin
            n_fail++;
            $display("FAIL sb_merge_strobe: cnt %0d k %0d wd %h want 1 1 dead55ef", we_cnt, we_k, we_wd);
        end
        n_assert++;
        if (mem[4] !== 32'hDEAD55EF) begin
            n_fail++;
            $display("FAIL sb_mem_word: got %h want dead55ef", mem[4]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_missing: got none want port %0d", e.port);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL sb_resp: got p%0d err %0d rdata %h lat %0d want p%0d err %0d rdata %h lat %0d",
                             o.port, o.err, o.rdata, o.lat, e.port, e.err, e.rdata, e.lat);
                end
            end
        end
    endtask

    task automatic test_loads;
        ev_t e, o;
        logic [2:0]  sz [5] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b000};
        logic [31:0] ad [5] = '{32'h13, 32'h12, 32'h12, 32'h11, 32'h10};
        logic [31:0] ex [5] = '{32'hFFFFFFDE, 32'h0000DEAD, 32'hFFFFDEAD, 32'h00000055, 32'hFFFFFFEF};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk_ev(1'b0, 1'b0, ex[i], 1));
            drive(1'b0, 1'b0, sz[i], ad[i], 32'h0);
            wait_acks(1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL load_missing: got none want rdata %h", e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL load: got p%0d err %0d rdata %h lat %0d want p%0d err %0d rdata %h lat %0d",
                             o.port, o.err, o.rdata, o.lat, e.port, e.err, e.rdata, e.lat);
                end
            end
        end
        repeat (3) @(negedge clk);
        #1;
        n_assert++;
        if (p0_rdata !== 32'hFFFFFFEF || p0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rdata_hold: got %h ack %0d want ffffffef ack 0", p0_rdata, p0_ack);
        end
        @(negedge clk);
    endtask

    task automatic test_errors;
        ev_t e, o;
        int err_we = 0;
        exp_q.push_back(mk_ev(1'b0, 1'b1, 32'h0, 1));
        drive(1'b0, 1'b0, 3'b010, 32'h12, 32'h0);
        wait_acks(1);
        err_we += we_cnt;
        exp_q.push_back(mk_ev(1'b1, 1'b1, 32'h0, 1));
        drive(1'b1, 1'b1, 3'b010, 32'h0010_0000, 32'h1111_2222);
        wait_acks(1);
        err_we += we_cnt;
        exp_q.push_back(mk_ev(1'b0, 1'b1, 32'h0, 1));
        drive(1'b0, 1'b1, 3'b001, 32'h13, 32'h3333);
        wait_acks(1);
        err_we += we_cnt;
        exp_q.push_back(mk_ev(1'b0, 1'b1, 32'h0, 1));
        drive(1'b0, 1'b0, 3'b011, 32'h10, 32'h0);
        wait_acks(1);
        err_we += we_cnt;
        n_assert++;
        if (err_we !== 0) begin
            n_fail++;
            $display("FAIL err_no_write: got %0d strobes want 0", err_we);
        end
        // Last in-range word must not be flagged.
        exp_q.push_back(mk_ev(1'b1, 1'b0, 32'h0, 1));
        drive(1'b1, 1'b1, 3'b010, 32'h000F_FFFC, 32'hCAFEF00D);
        wait_acks(1);
        exp_q.push_back(mk_ev(1'b1, 1'b0, 32'hCAFEF00D, 1));
        drive(1'b1, 1'b0, 3'b010, 32'h000F_FFFC, 32'h0);
        wait_acks(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL err_missing: got none want port %0d err %0d", e.port, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL err_resp: got p%0d err %0d rdata %h lat %0d want p%0d err %0d rdata %h lat %0d",
                             o.port, o.err, o.rdata, o.lat, e.port, e.err, e.rdata, e.lat);
                end
            end
        end
    endtask

    task automatic test_arbitration;
        ev_t e, o;
        test_reset();
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(mk_ev(1'b0, 1'b0, 32'hDEAD55EF, 1));
            exp_q.push_back(mk_ev(1'b1, 1'b0, 32'hCAFEF00D, 3));
            drive(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
            drive(1'b1, 1'b0, 3'b010, 32'h000F_FFFC, 32'h0);
            wait_acks(2);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL arb_missing: got none want port %0d", e.port);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL arb_order: got p%0d err %0d rdata %h lat %0d want p%0d err %0d rdata %h lat %0d",
                             o.port, o.err, o.rdata, o.lat, e.port, e.err, e.rdata, e.lat);
                end
            end
        end
    endtask

    task automatic test_reset_merge;
        ev_t e, o;
        int wr_before;
        int bad_ack = 0;
        drive(1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678);
        wait_acks(1);
        void'(obs_q.pop_front());
        wr_before = wr_cnt;
        drive(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000ABCD);
        #1;
        n_assert++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_idle_we: got %0d want 0", mem_we);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_merge_we: got %0d want 0", mem_we);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (p0_ack !== 1'b0 || mem_we !== 1'b0) bad_ack++;
        end
        n_assert++;
        if (bad_ack !== 0) begin
            n_fail++;
            $display("FAIL rst_merge_ack: got %0d cycles with ack/we want 0", bad_ack);
        end
        @(negedge clk);
        p0_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++;
        if (wr_cnt !== wr_before || mem[8] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rst_merge_mem: writes %0d word %h want %0d 12345678", wr_cnt - wr_before, mem[8], 0);
        end
        exp_q.push_back(mk_ev(1'b0, 1'b0, 32'h12345678, 1));
        drive(1'b0, 1'b0, 3'b010, 32'h20, 32'h0);
        wait_acks(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rst_reload_missing: got none want rdata %h", e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rst_reload: got p%0d err %0d rdata %h lat %0d want p%0d err %0d rdata %h lat %0d",
                             o.port, o.err, o.rdata, o.lat, e.port, e.err, e.rdata, e.lat);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        @(negedge clk);
        test_reset();
        test_word_rw();
        test_subword_store();
        test_loads();
        test_errors();
        test_arbitration();
        test_reset_merge();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
